// File: rtl/pipeline_sequencer_pkg.sv
// rtl/pipeline_sequencer_pkg.sv - shared types and constants for the pipeline sequencer
package pipeline_sequencer_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } seq_state_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXE = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  localparam logic HAZ_SEL_NOFWD = 1'b0;
  localparam logic HAZ_SEL_FWD   = 1'b1;
  localparam int   WCNT_W        = 8;

  function automatic logic tag_hit(logic wb_en, logic [3:0] dst, logic [3:0] src);
    return wb_en && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - stage tags in, hold/flush controls and counters out
interface pipeline_sequencer_if #(parameter int CNT_W = 16);

  logic             fwd_en;
  logic             id_valid;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic [3:0]       exe_dst;
  logic [3:0]       mem_dst;
  logic             exe_wb_en;
  logic             mem_wb_en;
  logic             exe_mem_read;
  logic             branch_taken;
  logic             mem_req;
  logic             sram_ready;
  logic             cnt_clr;
  logic             freeze_pc;
  logic             bubble_id;
  logic             flush;
  logic             freeze_all;
  logic             mem_abort;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] wait_cnt_total;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output fwd_en, id_valid, id_src1, id_src2, id_two_src, exe_dst, mem_dst,
           exe_wb_en, mem_wb_en, exe_mem_read, branch_taken, mem_req, sram_ready, cnt_clr,
    input  freeze_pc, bubble_id, flush, freeze_all, mem_abort, mem_error,
           stall_cnt, wait_cnt_total, flush_cnt
  );

  modport slave (
    input  fwd_en, id_valid, id_src1, id_src2, id_two_src, exe_dst, mem_dst,
           exe_wb_en, mem_wb_en, exe_mem_read, branch_taken, mem_req, sram_ready, cnt_clr,
    output freeze_pc, bubble_id, flush, freeze_all, mem_abort, mem_error,
           stall_cnt, wait_cnt_total, flush_cnt
  );

endinterface

// File: rtl/pipeline_sequencer_hazard_detect.sv
// rtl/pipeline_sequencer_hazard_detect.sv - combinational load-use / RAW hazard detection
module pipeline_sequencer_hazard_detect
  import pipeline_sequencer_pkg::*;
(
  input  logic       fwd_en_i,
  input  logic       id_valid_i,
  input  logic [3:0] id_src1_i,
  input  logic [3:0] id_src2_i,
  input  logic       id_two_src_i,
  input  logic [3:0] exe_dst_i,
  input  logic [3:0] mem_dst_i,
  input  logic       exe_wb_en_i,
  input  logic       mem_wb_en_i,
  input  logic       exe_mem_read_i,
  output logic       hazard_o
);

  logic exe_hit;
  logic mem_hit;

  always_comb begin
    exe_hit  = id_valid_i && (tag_hit(exe_wb_en_i, exe_dst_i, id_src1_i) ||
                              (id_two_src_i && tag_hit(exe_wb_en_i, exe_dst_i, id_src2_i)));
    mem_hit  = id_valid_i && (tag_hit(mem_wb_en_i, mem_dst_i, id_src1_i) ||
                              (id_two_src_i && tag_hit(mem_wb_en_i, mem_dst_i, id_src2_i)));
    hazard_o = 1'b0;
    // With forwarding only a load in EXE cannot be bypassed in time.
    case (fwd_en_i)
      HAZ_SEL_FWD:   hazard_o = exe_hit && exe_mem_read_i;
      HAZ_SEL_NOFWD: hazard_o = exe_hit || mem_hit;
    endcase
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - prioritised stall/flush/freeze control with saturating perf counters
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input logic                clk_i,
  input logic                rst_n_i,
  pipeline_sequencer_if.slave bus
);

  localparam logic [WCNT_W-1:0] TIMEOUT = WCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  seq_state_e        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_error_q, mem_error_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              hazard;
  logic              freeze_all;
  logic              mem_abort;
  logic              freeze_pc;
  logic              bubble_id;
  logic              flush;

  pipeline_sequencer_hazard_detect u_hazard (
    .fwd_en_i       (bus.fwd_en),
    .id_valid_i     (bus.id_valid),
    .id_src1_i      (bus.id_src1),
    .id_src2_i      (bus.id_src2),
    .id_two_src_i   (bus.id_two_src),
    .exe_dst_i      (bus.exe_dst),
    .mem_dst_i      (bus.mem_dst),
    .exe_wb_en_i    (bus.exe_wb_en),
    .mem_wb_en_i    (bus.mem_wb_en),
    .exe_mem_read_i (bus.exe_mem_read),
    .hazard_o       (hazard)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    mem_error_d = mem_error_q;
    freeze_all  = 1'b0;
    mem_abort   = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.mem_req && !bus.sram_ready) begin
          freeze_all = 1'b1;
          state_d    = ST_MEM_WAIT;
          wcnt_d     = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.sram_ready) begin
          state_d = ST_RUN;
        end else if (wcnt_q == TIMEOUT) begin
          // Abort releases the pipeline this cycle so it can make progress.
          mem_abort   = 1'b1;
          mem_error_d = 1'b1;
          state_d     = ST_RUN;
        end else begin
          freeze_all = 1'b1;
          wcnt_d     = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Frozen cycles leave branch/hazard inputs parked; they act once the freeze drops.
  always_comb begin
    freeze_pc = 1'b0;
    bubble_id = 1'b0;
    flush     = 1'b0;
    if (!freeze_all) begin
      if (bus.branch_taken) begin
        flush = 1'b1;
      end else if (hazard) begin
        freeze_pc = 1'b1;
        bubble_id = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      wait_cnt_d  = '0;
      flush_cnt_d = '0;
    end else begin
      if (bubble_id && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
      if (freeze_all && wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
      if (flush && flush_cnt_q != CNT_MAX)     flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      wcnt_q      <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.freeze_pc      = freeze_pc;
  assign bus.bubble_id      = bubble_id;
  assign bus.flush          = flush;
  assign bus.freeze_all     = freeze_all;
  assign bus.mem_abort      = mem_abort;
  assign bus.mem_error      = mem_error_q;
  assign bus.stall_cnt      = stall_cnt_q;
  assign bus.wait_cnt_total = wait_cnt_q;
  assign bus.flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed bench for pipeline_sequencer, default and small-parameter instances
module tb_pipeline_sequencer;

  typedef struct packed {
    logic       fwd_en;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic [3:0] exe_dst;
    logic [3:0] mem_dst;
    logic       exe_wb_en;
    logic       mem_wb_en;
    logic       exe_mem_read;
    logic       branch_taken;
    logic       mem_req;
    logic       sram_ready;
    logic       cnt_clr;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  stim_t stim = '0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(16)) ifa ();
  pipeline_sequencer_if #(.CNT_W(2))  ifb ();

  assign ifa.fwd_en = stim.fwd_en;             assign ifb.fwd_en = stim.fwd_en;
  assign ifa.id_valid = stim.id_valid;         assign ifb.id_valid = stim.id_valid;
  assign ifa.id_src1 = stim.id_src1;           assign ifb.id_src1 = stim.id_src1;
  assign ifa.id_src2 = stim.id_src2;           assign ifb.id_src2 = stim.id_src2;
  assign ifa.id_two_src = stim.id_two_src;     assign ifb.id_two_src = stim.id_two_src;
  assign ifa.exe_dst = stim.exe_dst;           assign ifb.exe_dst = stim.exe_dst;
  assign ifa.mem_dst = stim.mem_dst;           assign ifb.mem_dst = stim.mem_dst;
  assign ifa.exe_wb_en = stim.exe_wb_en;       assign ifb.exe_wb_en = stim.exe_wb_en;
  assign ifa.mem_wb_en = stim.mem_wb_en;       assign ifb.mem_wb_en = stim.mem_wb_en;
  assign ifa.exe_mem_read = stim.exe_mem_read; assign ifb.exe_mem_read = stim.exe_mem_read;
  assign ifa.branch_taken = stim.branch_taken; assign ifb.branch_taken = stim.branch_taken;
  assign ifa.mem_req = stim.mem_req;           assign ifb.mem_req = stim.mem_req;
  assign ifa.sram_ready = stim.sram_ready;     assign ifb.sram_ready = stim.sram_ready;
  assign ifa.cnt_clr = stim.cnt_clr;           assign ifb.cnt_clr = stim.cnt_clr;

  pipeline_sequencer dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(ifa));

  pipeline_sequencer #(.CNT_W(2), .MEM_TIMEOUT(3)) dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(ifb));

  logic        act_fpc[2], act_bub[2], act_fl[2], act_fz[2], act_ab[2], act_err[2];
  logic [15:0] act_sc[2], act_wc[2], act_fc[2];

  assign act_fpc[0] = ifa.freeze_pc;  assign act_fpc[1] = ifb.freeze_pc;
  assign act_bub[0] = ifa.bubble_id;  assign act_bub[1] = ifb.bubble_id;
  assign act_fl[0]  = ifa.flush;      assign act_fl[1]  = ifb.flush;
  assign act_fz[0]  = ifa.freeze_all; assign act_fz[1]  = ifb.freeze_all;
  assign act_ab[0]  = ifa.mem_abort;  assign act_ab[1]  = ifb.mem_abort;
  assign act_err[0] = ifa.mem_error;  assign act_err[1] = ifb.mem_error;
  assign act_sc[0]  = ifa.stall_cnt;  assign act_sc[1]  = 16'(ifb.stall_cnt);
  assign act_wc[0]  = ifa.wait_cnt_total; assign act_wc[1] = 16'(ifb.wait_cnt_total);
  assign act_fc[0]  = ifa.flush_cnt;  assign act_fc[1]  = 16'(ifb.flush_cnt);

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: a dependency counts if a writing stage targets a register ID reads.
  function automatic bit ref_hazard(stim_t s);
    bit e1 = s.exe_wb_en && s.exe_dst == s.id_src1;
    bit e2 = s.id_two_src && s.exe_wb_en && s.exe_dst == s.id_src2;
    bit m1 = s.mem_wb_en && s.mem_dst == s.id_src1;
    bit m2 = s.id_two_src && s.mem_wb_en && s.mem_dst == s.id_src2;
    if (!s.id_valid) return 1'b0;
    if (s.fwd_en) return (e1 || e2) && s.exe_mem_read;
    return e1 || e2 || m1 || m2;
  endfunction

  int    tmo[2]  = '{255, 3};
  int    cmax[2] = '{65535, 3};
  string dn[2]   = '{"A", "B"};
  int    m_waited[2], m_sc[2], m_wc[2], m_fc[2];
  bit    m_err[2];

  // m_waited: consecutive not-ready cycles of the outstanding SRAM access (0 = none).
  always @(negedge clk) begin
    bit fz, ab, fl, bb;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_waited[d] = 0; m_err[d] = 0; m_sc[d] = 0; m_wc[d] = 0; m_fc[d] = 0;
      end
      fz = 0; ab = 0;
      if (m_waited[d] == 0) fz = stim.mem_req && !stim.sram_ready;
      else if (!stim.sram_ready) begin
        if (m_waited[d] >= tmo[d]) ab = 1; else fz = 1;
      end
      fl = !fz && stim.branch_taken;
      bb = !fz && !stim.branch_taken && ref_hazard(stim);
      chk({dn[d], ".freeze_all"}, int'(act_fz[d]), int'(fz));
      chk({dn[d], ".mem_abort"},  int'(act_ab[d]), int'(ab));
      chk({dn[d], ".flush"},      int'(act_fl[d]), int'(fl));
      chk({dn[d], ".bubble_id"},  int'(act_bub[d]), int'(bb));
      chk({dn[d], ".freeze_pc"},  int'(act_fpc[d]), int'(bb));
      chk({dn[d], ".mem_error"},  int'(act_err[d]), int'(m_err[d]));
      chk({dn[d], ".stall_cnt"},  int'(act_sc[d]), m_sc[d]);
      chk({dn[d], ".wait_cnt"},   int'(act_wc[d]), m_wc[d]);
      chk({dn[d], ".flush_cnt"},  int'(act_fc[d]), m_fc[d]);
      if (rst_n) begin
        if (m_waited[d] == 0) m_waited[d] = fz ? 1 : 0;
        else if (stim.sram_ready || ab) m_waited[d] = 0;
        else m_waited[d]++;
        if (ab) m_err[d] = 1;
        if (stim.cnt_clr) begin
          m_sc[d] = 0; m_wc[d] = 0; m_fc[d] = 0;
        end else begin
          if (bb && m_sc[d] < cmax[d]) m_sc[d]++;
          if (fz && m_wc[d] < cmax[d]) m_wc[d]++;
          if (fl && m_fc[d] < cmax[d]) m_fc[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    rst_n = 1'b1;
    chk("reset_stall_cnt_A", int'(ifa.stall_cnt), 0);
    chk("reset_state_freeze_A", int'(ifa.freeze_all), 0);

    // Load-use with forwarding: r3 loaded in EXE, read by ID.
    stim.fwd_en = 1; stim.id_valid = 1; stim.id_src1 = 3;
    stim.exe_dst = 3; stim.exe_wb_en = 1; stim.exe_mem_read = 1;
    #2 chk("lduse_bubble", int'(ifa.bubble_id), 1);
    tick();
    stim.exe_dst = 0; stim.exe_wb_en = 0; stim.exe_mem_read = 0;
    stim.mem_dst = 3; stim.mem_wb_en = 1;
    #2 chk("lduse_clear_next", int'(ifa.bubble_id), 0);
    tick();
    stim = '0;
    chk("lduse_stall_cnt", int'(ifa.stall_cnt), 1);

    // No forwarding, MEM writes r5, ID src2=r5.
    stim.id_valid = 1; stim.id_src2 = 5; stim.id_two_src = 1;
    stim.mem_dst = 5; stim.mem_wb_en = 1;
    #2 chk("nofwd_src2_stall", int'(ifa.freeze_pc), 1);
    tick();
    stim.id_two_src = 0;
    #2 chk("nofwd_one_src_nostall", int'(ifa.freeze_pc), 0);
    tick();
    stim = '0;

    // SRAM never ready for 4 cycles: A waits, B (timeout 3) aborts on the 4th.
    stim.mem_req = 1;
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk("wait_freeze_A", int'(ifa.freeze_all), 1);
      chk("tmo_abort_B", int'(ifb.mem_abort), (i == 4) ? 1 : 0);
      chk("tmo_freeze_B", int'(ifb.freeze_all), (i == 4) ? 0 : 1);
      tick();
    end
    stim.mem_req = 0; stim.sram_ready = 1;
    chk("tmo_error_B", int'(ifb.mem_error), 1);
    #2 chk("wait_release_A", int'(ifa.freeze_all), 0);
    tick();
    stim = '0;
    chk("wait_cnt_A", int'(ifa.wait_cnt_total), 4);

    // Branch together with a load-use hazard.
    stim.fwd_en = 1; stim.id_valid = 1; stim.id_src1 = 9;
    stim.exe_dst = 9; stim.exe_wb_en = 1; stim.exe_mem_read = 1; stim.branch_taken = 1;
    #2;
    chk("br_haz_flush", int'(ifa.flush), 1);
    chk("br_haz_nobubble", int'(ifa.bubble_id), 0);
    tick();
    stim = '0;
    chk("br_haz_flush_cnt", int'(ifa.flush_cnt), 1);
    chk("br_haz_stall_cnt", int'(ifa.stall_cnt), 2);

    // Branch parked behind an SRAM wait.
    stim.mem_req = 1; stim.branch_taken = 1;
    for (int i = 1; i <= 3; i++) begin
      #2 chk("br_wait_noflush", int'(ifa.flush), 0);
      tick();
    end
    stim.sram_ready = 1;
    #2 chk("br_wait_flush_on_ready", int'(ifa.flush), 1);
    tick();
    stim = '0;
    chk("br_wait_flush_cnt", int'(ifa.flush_cnt), 2);

    // Five stall cycles: B's 2-bit counter saturates at 3.
    stim.id_valid = 1; stim.id_src1 = 7; stim.exe_dst = 7; stim.exe_wb_en = 1;
    repeat (5) tick();
    stim = '0;
    chk("sat_stall_cnt_B", int'(ifb.stall_cnt), 3);
    chk("sat_stall_cnt_A", int'(ifa.stall_cnt), 7);

    // Clear wins over a simultaneous stall.
    stim.id_valid = 1; stim.id_src1 = 7; stim.exe_dst = 7; stim.exe_wb_en = 1; stim.cnt_clr = 1;
    tick();
    stim = '0;
    chk("clr_stall_cnt_A", int'(ifa.stall_cnt), 0);
    chk("clr_wait_cnt_A", int'(ifa.wait_cnt_total), 0);
    chk("clr_flush_cnt_A", int'(ifa.flush_cnt), 0);
    chk("clr_error_sticky_B", int'(ifb.mem_error), 1);

    // Asynchronous reset in the middle of an SRAM wait.
    stim.mem_req = 1;
    repeat (2) tick();
    stim.mem_req = 0;
    chk("pre_rst_freeze_A", int'(ifa.freeze_all), 1);
    chk("pre_rst_wait_cnt_A", int'(ifa.wait_cnt_total), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_freeze_A", int'(ifa.freeze_all), 0);
    chk("rst_mid_wait_cnt_A", int'(ifa.wait_cnt_total), 0);
    chk("rst_mid_error_B", int'(ifb.mem_error), 0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush controller for the 5-stage ARM pipeline. It combines load-use and RAW hazard detection, branch-flush control and multi-cycle SRAM wait-state freezing into one prioritised set of per-stage hold/flush signals. It also keeps saturating performance counters. It sits beside the forwarding unit, takes ID/EXE/MEM stage tags, and drives the freeze/flush inputs of the PC and pipeline registers.

## Interface
- `CNT_W`, 16, width of each performance counter.
- `MEM_TIMEOUT`, 255, maximum consecutive SRAM wait cycles before abort; legal range 1..2^8-1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `fwd_en`  in  1  forwarding enabled (1) or disabled (0).
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_src1`, `id_src2`  in  4  ID source registers.
- `id_two_src`  in  1  ID instruction reads `id_src2`.
- `exe_dst`, `mem_dst`  in  4  destination registers of EXE and MEM.
- `exe_wb_en`, `mem_wb_en`  in  1  EXE / MEM will write back.
- `exe_mem_read`  in  1  EXE instruction is a load.
- `branch_taken`  in  1  EXE resolved a taken branch.
- `mem_req`  in  1  MEM stage accessing SRAM this cycle.
- `sram_ready`  in  1  SRAM completes the access this cycle.
- `cnt_clr`  in  1  synchronous clear of all counters.
- `freeze_pc`  out  1  hold PC and IF/ID.
- `bubble_id`  out  1  load NOP into ID/EXE.
- `flush`  out  1  clear IF/ID and ID/EXE.
- `freeze_all`  out  1  hold every pipeline register and PC.
- `mem_abort`  out  1  one-cycle pulse, SRAM wait timed out.
- `mem_error`  out  1  sticky timeout flag; cleared only by reset.
- `stall_cnt`, `wait_cnt_total`, `flush_cnt`  out  CNT_W  hazard-stall cycles, SRAM-freeze cycles, flush events.

## Operation
- Hazard, combinational:
  - `src1_hit(X)` = `id_valid` & X_wb_en & X_dst==`id_src1`.
  - `src2_hit(X)` = `id_valid` & `id_two_src` & X_wb_en & X_dst==`id_src2`.
  - `fwd_en`=0: hazard = any hit against EXE or MEM.
  - `fwd_en`=1: hazard = (src1_hit(EXE) | src2_hit(EXE)) & `exe_mem_read`.
- FSM states RUN, MEM_WAIT; internal wait counter `wcnt`, 8 bits.
- RUN:
  - `mem_req` & !`sram_ready` → `freeze_all`=1 this cycle; next state MEM_WAIT, `wcnt`=1.
  - `mem_req` & `sram_ready` → zero-wait access, no freeze.
- MEM_WAIT:
  - `freeze_all` = !`sram_ready`.
  - `sram_ready`=1 → next RUN.
  - Else if `wcnt`==MEM_TIMEOUT → `mem_abort`=1, `freeze_all`=0 this cycle, `mem_error`<=1, next RUN.
  - Else `wcnt`++.
- Output priority:
  - `freeze_all`=1 forces `freeze_pc`=`bubble_id`=`flush`=0. A pending `branch_taken` or hazard is held and is acted on the first unfrozen cycle.
  - Else `branch_taken` → `flush`=1, with `freeze_pc`=`bubble_id`=0; a branch squashes any hazard stall.
  - Else hazard → `freeze_pc`=1, `bubble_id`=1.
- Counters, all saturating at 2^CNT_W-1; `cnt_clr` has priority over increment:
  - `stall_cnt` +1 per cycle with `bubble_id`.
  - `wait_cnt_total` +1 per cycle with `freeze_all`.
  - `flush_cnt` +1 per cycle with `flush`.

## Timing
- Reset values: state RUN; `wcnt`, all counters, `mem_error`, `mem_abort` = 0. Other outputs are combinational and are 0 with idle inputs.
- Control outputs are Mealy: asserted in the same cycle as the causing inputs, with zero latency.
- State, `wcnt`, counters and `mem_error` update on the rising `clk` edge.
- Reset asserted mid-wait returns to RUN immediately (asynchronous); counters clear.
- Load-use with forwarding gives exactly 1 bubble cycle; the next cycle the load is in MEM and the hazard clears.
- Without forwarding, a dependency gives up to 2 stall cycles.

## Structure
- State encodings and the hazard-select constants go in the shared defines file alongside the forwarding selects.
- One sub-module: `hazard_detect`, purely combinational, producing `hazard` from the ID/EXE/MEM tags and `fwd_en`.
- FSM, priority logic and counters stay in `pipeline_sequencer`.

## Test plan
- Forwarding on, EXE load r3, ID reads r3 as src1 → `freeze_pc`=`bubble_id`=1 for exactly 1 cycle, `stall_cnt`=1.
- Forwarding off, MEM writes r5, ID `id_two_src`=1 with src2=r5 → stall asserted; `id_two_src`=0 → no stall.
- `mem_req`=1, `sram_ready` low 4 cycles then high → `freeze_all`=1 for 4 cycles, `wait_cnt_total`=4, state back to RUN.
- MEM_TIMEOUT=3, `sram_ready` never rises → `mem_abort` pulses on the 4th cycle after entry, `mem_error`=1 sticky.
- Simultaneous events:
  - `branch_taken` + hazard → `flush`=1, no bubble, `flush_cnt`=1.
  - `branch_taken` during MEM_WAIT → flush only on the cycle `sram_ready` rises.
- Counter behaviour:
  - CNT_W=2 with 5 stall cycles → `stall_cnt`=3 (saturated).
  - `cnt_clr` together with a stall → counters read 0 next cycle.
